zle_decode: RTL

ZLE_DECODE -- requirements
Module: zle_decode

---
 rtl/zle_pkg.sv | 29 ++
 rtl/zle_decode_if.sv | 35 +++
 rtl/zle_decode_fsm.sv | 99 +++++++++
 rtl/zle_decode.sv | 69 ++++++
 4 files changed

// File: rtl/zle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zle_pkg
// Purpose  : Shared definitions for the zero-length-encoding decoder:
//            FSM state encoding, default widths and the tag bit position.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package zle_pkg;

    // Decoder states. PASS forwards tokens; EXPAND emits the remaining
    // zeros of a run.
    typedef enum logic [0:0] {
        PASS   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNTW  = 4;

    // The tag sits directly above the data field.
    localparam int DEF_TAG_BIT = DEF_WIDTH;

    function automatic int tag_bit(input int width);
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zle_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : zle_decode_if
// Purpose  : Token-in / word-out stream bundle for zle_decode.
// Signals  : i_d  encoded token (tag at bit WIDTH)
//            i_v  token valid            i_b  token back-pressure
//            o_d  decoded word           o_v  word valid
//            o_b  word back-pressure
// Modports : master - stream producer/consumer around the decoder
//            slave  - the decoder itself
// Revision : 1.0 - initial release
// ============================================================================
interface zle_decode_if
    import zle_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH:0]   i_d;
    logic             i_v;
    logic             i_b;
    logic [WIDTH-1:0] o_d;
    logic             o_v;
    logic             o_b;

    modport master (
        output i_d, i_v, o_b,
        input  i_b, o_d, o_v
    );

    modport slave (
        input  i_d, i_v, o_b,
        output i_b, o_d, o_v
    );
endinterface
`default_nettype wire

// File: rtl/zle_decode_fsm.sv
`default_nettype none
// ============================================================================
// Module   : zle_decode_fsm
// Purpose  : Control for the ZLE decoder: PASS/EXPAND state, remaining run
//            count and both handshakes.
// Ports    : clock, reset (async, active-low)
//            in_valid  token valid          in_tag    token tag (1 = run)
//            in_count  run count field      out_stall downstream back-pressure
//            in_stall  token back-pressure  out_valid output word valid
//            out_zero  current output word is a zero from a run token
// Revision : 1.0 - initial release
// ============================================================================
module zle_decode_fsm
    import zle_pkg::*;
#(
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_tag,
    input  logic [CNTW-1:0] in_count,
    input  logic            out_stall,
    output logic            in_stall,
    output logic            out_valid,
    output logic            out_zero
);

    state_t          state;
    state_t          state_next;
    logic [CNTW-1:0] rem;
    logic [CNTW-1:0] rem_next;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= PASS;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // Next-state logic. A run token emits its first zero in PASS, so only
    // the remaining count (n) is loaded for EXPAND; n == 0 never leaves PASS.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        case (state)
            PASS: begin
                if (in_valid && !out_stall && in_tag && (in_count != '0)) begin
                    state_next = EXPAND;
                    rem_next   = in_count;
                end
            end
            EXPAND: begin
                if (!out_stall) begin
                    if (rem == CNTW'(1)) begin
                        state_next = PASS;
                    end
                    rem_next = rem - CNTW'(1);
                end
            end
            default: begin
                state_next = PASS;
                rem_next   = '0;
            end
        endcase
    end

    // Output logic. In PASS a token is only taken when the word can leave
    // in the same cycle, which gives zero latency without a holding register.
    always_comb begin
        in_stall  = 1'b1;
        out_valid = 1'b0;
        out_zero  = 1'b0;
        case (state)
            PASS: begin
                if (in_valid && !out_stall) begin
                    in_stall  = 1'b0;
                    out_valid = 1'b1;
                    out_zero  = in_tag;
                end
            end
            EXPAND: begin
                out_valid = 1'b1;
                out_zero  = 1'b1;
            end
            default: begin
                in_stall  = 1'b1;
                out_valid = 1'b0;
                out_zero  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/zle_decode.sv
`default_nettype none
// ============================================================================
// Module   : zle_decode
// Purpose  : Zero-length-encoding stream decoder. Data tokens pass through
//            unchanged; a run token with count n expands to n+1 zero words.
// Ports    : clock   rising-edge clock
//            reset   asynchronous, active-low reset
//            bus     zle_decode_if.slave (i_d/i_v/i_b in, o_d/o_v/o_b out)
//            zcount  running total of zeros emitted from run tokens
//                    (only when ZLE_DECODE_CNT_EN is defined)
// Config   : ZLE_DECODE_CNT_EN - adds the zcount port and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module zle_decode
    import zle_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic        clock,
    input  logic        reset,
    zle_decode_if.slave bus
`ifdef ZLE_DECODE_CNT_EN
    ,
    output logic [31:0] zcount
`endif
);

    localparam int TAG = tag_bit(WIDTH);

    logic in_stall;
    logic out_valid;
    logic out_zero;

    zle_decode_fsm #(
        .CNTW (CNTW)
    ) u_fsm (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (bus.i_v),
        .in_tag    (bus.i_d[TAG]),
        .in_count  (bus.i_d[CNTW-1:0]),
        .out_stall (bus.o_b),
        .in_stall  (in_stall),
        .out_valid (out_valid),
        .out_zero  (out_zero)
    );

    assign bus.i_b = in_stall;
    assign bus.o_v = out_valid;

    // Data words come straight from the token; run zeros and idle cycles
    // both force the bus to zero.
    assign bus.o_d = (out_valid && !out_zero) ? bus.i_d[WIDTH-1:0] : '0;

`ifdef ZLE_DECODE_CNT_EN
    // Counts only zeros that actually transfer; a plain data word of value
    // zero is not part of a run and is not counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            zcount <= '0;
        end else if (out_valid && out_zero && !bus.o_b) begin
            zcount <= zcount + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
